sphere_scene_buffer: RTL and testbench
======================================

Name: sphere_scene_buffer

Overview:
- Double-buffered, parametrised sphere table between the scene loader (MCU/SPI side) and the per-pixel ray/sphere intersection pipeline.
- The loader writes spheres into the back bank while the renderer streams the front bank's valid spheres, one per handshake, for each pixel.
- Banks swap at frame boundary (vsync) only after the loader commits a scene, so a frame never renders a half-written scene.

Parameters:
N_SPHERES, 8, table depth per bank (power of two, 2..64)
X_B, 16, signed fixed-point sphere X width (13 int + 3 frac)
Y_B, 15, signed fixed-point sphere Y width
Z_B, 15, signed fixed-point sphere Z width
R_B, 6, radius width
C_B, 12, colour width (4:4:4 RGB)
Derived: IDX_B = $clog2(N_SPHERES); SPH_B = X_B+Y_B+Z_B+R_B+C_B; packed order MSB->LSB {x,y,z,r,c}

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_valid  in  1  loader write strobe
wr_ready  out  1  back bank writable
wr_idx  in  IDX_B  target entry
wr_sphere  in  SPH_B  packed sphere
wr_commit  in  1  pulse: back bank complete, request swap
swap_req  in  1  pulse: frame boundary (vsync)
swap_done  out  1  one-cycle pulse when banks swapped
rd_start  in  1  pulse: begin streaming for one pixel
rd_valid  out  1  rd_sphere valid
rd_ready  in  1  consumer accepts
rd_sphere  out  SPH_B  streamed sphere
rd_last  out  1  qualifies rd_valid: final sphere of stream
rd_done  out  1  one-cycle pulse: stream finished
n_active  out  $clog2(N_SPHERES+1)  popcount of front-bank valid mask

Behaviour:
- Reset (async): both valid masks 0, front bank = 0, commit_pending 0, FSM IDLE, wr_ready 1, rd_valid/rd_last/rd_done/swap_done 0, rd_sphere 0, n_active 0. Data RAM contents undefined (masks gate all use).
- Write: wr_valid & wr_ready -> back[wr_idx] <= wr_sphere, back_mask[wr_idx] <= 1, same cycle. Overwriting an index is legal.
- wr_ready = !commit_pending. wr_valid while wr_ready=0 is dropped.
- wr_commit sets commit_pending; a write in the same cycle as wr_commit is performed and included.
- Swap: taken on the cycle where (swap_req or swap_deferred) & commit_pending & FSM==IDLE & !rd_start. Action: toggle front bank, clear new back mask, clear commit_pending, pulse swap_done next cycle.
- swap_req arriving while FSM!=IDLE or rd_start same cycle sets swap_deferred; swap fires the first cycle those clear. swap_req without commit_pending is ignored (not remembered).
- Stream FSM IDLE -> SCAN -> IDLE. rd_start in IDLE: pointer p <= 0, enter SCAN. rd_start outside IDLE ignored.
- SCAN: one index examined per cycle, only when output slot is free (rd_valid=0 or rd_valid&rd_ready this cycle). Valid entry at p -> load rd_sphere, rd_valid<=1, rd_last <= no valid entry above p; invalid -> skip. p++ either way.
- Contiguous valid entries with rd_ready held high: one sphere per cycle; first rd_valid at rd_start+1 cycle when entry 0 valid.
- rd_sphere/rd_last held stable while rd_valid & !rd_ready.
- Stream end: handshake on rd_last -> rd_valid 0, rd_done pulse next cycle, IDLE. Empty front mask: rd_done pulses rd_start+1, no rd_valid.
- Front bank is never written; swap cannot occur mid-stream.
- n_active registered, updates cycle after swap.

Optional Feature:
- SCENE_RADIUS_CULL_EN defined: entries whose r field == 0 are treated as invalid for streaming, rd_last and n_active (still stored).
- Undefined: r is ignored for validity; zero-radius spheres stream normally.

Test Plan:
- Reset, write idx 0,1,2 (c=12'hF00,0F0,00F), commit, swap_req -> swap_done 1 cycle later, n_active=3, wr_ready 1 again; rd_start with rd_ready=1 -> rd_valid 3 consecutive cycles, colours F00,0F0,00F, rd_last on third, rd_done next cycle.
- Front mask {1,4,7} of N=8 -> exactly 3 beats in index order, rd_last only on idx 7; rd_ready toggled 1/0 -> data held stable while stalled.
- swap_req during active stream with commit_pending -> no swap until rd_done; swap_done one cycle after stream ends; second swap_req with no commit -> no swap_done.
- Write after commit (wr_ready=0) to idx 5 -> not present after swap (n_active unchanged); write + commit same cycle -> included.
- Empty scene swapped in, rd_start -> rd_done at +1, rd_valid never 1; assert rst mid-stream -> all outputs 0 immediately, n_active 0.
- SCENE_RADIUS_CULL_EN: entries 0..3 with r=5,0,3,0 -> n_active=2, stream idx 0 then 2 with rd_last on 2; macro off -> n_active=4, 4 beats.

Source files
------------

// File: rtl/sphere_scene_buffer_if.sv
// Loader/renderer bundle for sphere_scene_buffer; master = scene loader + pixel pipeline, slave = buffer.
// Handshake: a transfer happens on every rising clk edge where valid && ready; once raised, valid and its payload are held until that edge.
interface sphere_scene_buffer_if #(
  parameter int IDX_B = 3,
  parameter int SPH_B = 64,
  parameter int CNT_B = 4
);
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_B-1:0] wr_idx;
  logic [SPH_B-1:0] wr_sphere;
  logic             wr_commit;
  logic             swap_req;
  logic             swap_done;
  logic             rd_start;
  logic             rd_valid;
  logic             rd_ready;
  logic [SPH_B-1:0] rd_sphere;
  logic             rd_last;
  logic             rd_done;
  logic [CNT_B-1:0] n_active;
  logic             dbg_state;

  modport master (
    output wr_valid, wr_idx, wr_sphere, wr_commit, swap_req, rd_start, rd_ready,
    input  wr_ready, swap_done, rd_valid, rd_sphere, rd_last, rd_done, n_active, dbg_state
  );
  modport slave (
    input  wr_valid, wr_idx, wr_sphere, wr_commit, swap_req, rd_start, rd_ready,
    output wr_ready, swap_done, rd_valid, rd_sphere, rd_last, rd_done, n_active, dbg_state
  );
endinterface

// File: rtl/sphere_scene_buffer.sv
// Double-buffered sphere table: loader fills the back bank, renderer streams the front bank per pixel.
// Optional macro SCENE_RADIUS_CULL_EN: zero-radius entries are excluded from streaming and n_active.
module sphere_scene_buffer #(
  parameter int N_SPHERES = 8,
  parameter int X_B = 16,
  parameter int Y_B = 15,
  parameter int Z_B = 15,
  parameter int R_B = 6,
  parameter int C_B = 12
) (
  input logic clk,
  input logic rst,
  sphere_scene_buffer_if.slave bus
);
  localparam int IDX_B = $clog2(N_SPHERES);
  localparam int SPH_B = X_B + Y_B + Z_B + R_B + C_B;
  localparam int CNT_B = $clog2(N_SPHERES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [SPH_B-1:0]     ram [2][N_SPHERES];
  logic [N_SPHERES-1:0] mask [2];
  logic                 front;
  logic                 back;
  logic                 commit_pending;
  logic                 swap_deferred;
  logic [0:0]           state;
  logic [IDX_B-1:0]     p;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic                 rd_done_q;
  logic                 swap_done_q;
  logic [SPH_B-1:0]     rd_sphere_q;
  logic [CNT_B-1:0]     n_active_q;

  logic [N_SPHERES-1:0] eff_f;
  logic [N_SPHERES-1:0] eff_b;
  logic [IDX_B-1:0]     exam_idx;
  logic                 exam_valid;
  logic                 exam_last;
  logic                 wr_fire;
  logic                 swap_go;
  logic                 slot_free;

  function automatic logic [CNT_B-1:0] popcnt(input logic [N_SPHERES-1:0] m);
    logic [CNT_B-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_SPHERES; i++) acc = acc + CNT_B'(m[i]);
    return acc;
  endfunction

  assign back = ~front;

  // Effective validity: the stored mask, optionally further gated by a non-zero radius.
  always_comb begin
    eff_f = '0;
    eff_b = '0;
    for (int i = 0; i < N_SPHERES; i++) begin
`ifdef SCENE_RADIUS_CULL_EN
      eff_f[i] = mask[front][i] & (ram[front][i][C_B +: R_B] != '0);
      eff_b[i] = mask[back][i]  & (ram[back][i][C_B +: R_B] != '0);
`else
      eff_f[i] = mask[front][i];
      eff_b[i] = mask[back][i];
`endif
    end
  end

  // rd_start examines entry 0 directly so a valid entry 0 appears the very next cycle.
  assign exam_idx   = (state == S_IDLE) ? '0 : p;
  assign exam_valid = eff_f[exam_idx];
  assign exam_last  = ((eff_f >> exam_idx) >> 1) == '0;
  assign wr_fire    = bus.wr_valid & ~commit_pending;
  assign swap_go    = (bus.swap_req | swap_deferred) & commit_pending &
                      (state == S_IDLE) & ~bus.rd_start;
  assign slot_free  = ~rd_valid_q | bus.rd_ready;

  always_ff @(posedge clk) begin
    if (wr_fire) ram[back][bus.wr_idx] <= bus.wr_sphere;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask[0]        <= '0;
      mask[1]        <= '0;
      front          <= 1'b0;
      commit_pending <= 1'b0;
      swap_deferred  <= 1'b0;
      state          <= S_IDLE;
      p              <= '0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      swap_done_q    <= 1'b0;
      rd_sphere_q    <= '0;
      n_active_q     <= '0;
    end else begin
      rd_done_q   <= 1'b0;
      swap_done_q <= 1'b0;
      n_active_q  <= swap_go ? popcnt(eff_b) : popcnt(eff_f);

      if (wr_fire) mask[back][bus.wr_idx] <= 1'b1;
      if (bus.wr_commit) commit_pending <= 1'b1;

      if (swap_go) begin
        swap_deferred  <= 1'b0;
        front          <= back;
        mask[front]    <= '0;
        commit_pending <= 1'b0;
        swap_done_q    <= 1'b1;
      end else if (bus.swap_req & commit_pending) begin
        swap_deferred <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bus.rd_start) begin
            if (eff_f == '0) begin
              rd_done_q <= 1'b1;
            end else begin
              state <= S_SCAN;
              p     <= IDX_B'(1);
              if (exam_valid) begin
                rd_valid_q  <= 1'b1;
                rd_sphere_q <= ram[front][exam_idx];
                rd_last_q   <= exam_last;
              end
            end
          end
        end
        default: begin
          if (slot_free) begin
            if (rd_valid_q && rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              rd_done_q  <= 1'b1;
              state      <= S_IDLE;
            end else begin
              p <= p + IDX_B'(1);
              if (exam_valid) begin
                rd_valid_q  <= 1'b1;
                rd_sphere_q <= ram[front][exam_idx];
                rd_last_q   <= exam_last;
              end else begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_ready  = ~commit_pending;
  assign bus.swap_done = swap_done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_sphere = rd_sphere_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.n_active  = n_active_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_sphere_scene_buffer.sv
// Self-checking bench for sphere_scene_buffer: scene-level model (back/front tables) plus a stream scoreboard.
module tb_sphere_scene_buffer;
  localparam int N = 8;
  localparam int X_B = 16, Y_B = 15, Z_B = 15, R_B = 6, C_B = 12;
  localparam int IDX_B = 3;
  localparam int SPH_B = X_B + Y_B + Z_B + R_B + C_B;
  localparam int CNT_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  sphere_scene_buffer_if #(.IDX_B(IDX_B), .SPH_B(SPH_B), .CNT_B(CNT_B)) bus ();

  sphere_scene_buffer #(.N_SPHERES(N), .X_B(X_B), .Y_B(Y_B), .Z_B(Z_B), .R_B(R_B), .C_B(C_B))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scene model: back and front tables as the loader and renderer see them
  logic [SPH_B-1:0] m_back [N];
  logic [SPH_B-1:0] m_front [N];
  bit               m_bv [N];
  bit               m_fv [N];
  bit               m_pending;

  // scoreboard state
  logic [SPH_B:0]   exp_q [$];
  logic [SPH_B-1:0] beat_sph [$];
  bit               beat_last [$];
  int               beat_cyc [$];
  bit               stream_active = 0;
  int               mon_first_valid = -1;
  int               mon_done_cyc = -1;
  int               swap_cnt = 0;
  int               swap_cyc = -1;
  bit               prev_stall = 0;
  logic [SPH_B-1:0] prev_sph;
  logic             prev_last;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SPH_B-1:0] mk(input int x, input int y, input int z, input int r, input int c);
    return {X_B'(x), Y_B'(y), Z_B'(z), R_B'(r), C_B'(c)};
  endfunction

  function automatic bit r_ok(input logic [SPH_B-1:0] s);
`ifdef SCENE_RADIUS_CULL_EN
    return s[C_B +: R_B] != '0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_eff(input int i);
    return m_fv[i] && r_ok(m_front[i]);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_eff(i)) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0;
      m_fv[i] = 0;
    end
    m_pending = 0;
  endtask

  task automatic model_swap();
    for (int i = 0; i < N; i++) begin
      m_front[i] = m_back[i];
      m_fv[i]    = m_bv[i];
      m_bv[i]    = 0;
    end
    m_pending = 0;
  endtask

  // compare process: stream beats, stall stability, stray outputs
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.swap_done) begin
        swap_cnt++;
        swap_cyc = cyc;
      end
      if (!stream_active) check("idle_valid", bus.rd_valid, 1'b0);
      if (prev_stall) check("stall_hold", {bus.rd_valid, bus.rd_last, bus.rd_sphere}, {1'b1, prev_last, prev_sph});
      if (bus.rd_valid && mon_first_valid < 0) mon_first_valid = cyc;
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", {bus.rd_last, bus.rd_sphere}, '1);
        end else begin
          check("beat", {bus.rd_last, bus.rd_sphere}, exp_q.pop_front());
        end
        beat_sph.push_back(bus.rd_sphere);
        beat_last.push_back(bus.rd_last);
        beat_cyc.push_back(cyc);
      end
      if (bus.rd_done) mon_done_cyc = cyc;
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_sph   = bus.rd_sphere;
      prev_last  = bus.rd_last;
    end
  end

  // driver tasks
  task automatic write_op(input bit v, input int idx, input logic [SPH_B-1:0] s, input bit c);
    @(posedge clk); #1;
    bus.wr_valid = v; bus.wr_idx = IDX_B'(idx); bus.wr_sphere = s; bus.wr_commit = c;
    @(negedge clk);
    check("wr_ready", bus.wr_ready, !m_pending);
    if (v && !m_pending) begin
      m_back[idx] = s;
      m_bv[idx]   = 1;
    end
    if (c) m_pending = 1;
    @(posedge clk); #1;
    bus.wr_valid = 0; bus.wr_commit = 0;
  endtask

  task automatic do_swap();
    bit expect_swap;
    int s0;
    expect_swap = m_pending;
    s0 = swap_cnt;
    @(posedge clk); #1; bus.swap_req = 1;
    @(posedge clk); #1; bus.swap_req = 0;
    @(negedge clk); #1;
    check("swap_done", bus.swap_done, expect_swap);
    if (expect_swap) model_swap();
    check("n_active", bus.n_active, m_count());
    check("wr_ready_after_swap", bus.wr_ready, !m_pending);
    @(negedge clk); #1;
    check("swap_pulse_width", swap_cnt - s0, expect_swap ? 1 : 0);
  endtask

  function automatic bit ready_val(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  int start_at;
  task automatic run_stream(input int mode);
    int last_i, n;
    bit got;
    last_i = -1;
    n = 0;
    got = 0;
    for (int i = 0; i < N; i++) if (m_eff(i)) last_i = i;
    for (int i = 0; i < N; i++)
      if (m_eff(i)) begin
        exp_q.push_back({(i == last_i), m_front[i]});
        n++;
      end
    stream_active = 1;
    mon_first_valid = -1;
    mon_done_cyc = -1;
    beat_sph.delete(); beat_last.delete(); beat_cyc.delete();
    @(posedge clk); #1;
    bus.rd_start = 1; bus.rd_ready = ready_val(mode, 0); start_at = cyc;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      bus.rd_start = 0; bus.rd_ready = ready_val(mode, k + 1);
      @(negedge clk); #1;
      if (mon_done_cyc >= 0) begin
        got = 1;
        break;
      end
    end
    bus.rd_ready = 0;
    stream_active = 0;
    check("stream_done_seen", got, 1'b1);
    check("exp_drained", exp_q.size(), 0);
    check("beat_count", beat_sph.size(), n);
    exp_q.delete();
  endtask

  int s0;
  initial begin
    bus.wr_valid = 0; bus.wr_idx = '0; bus.wr_sphere = '0; bus.wr_commit = 0;
    bus.swap_req = 0; bus.rd_start = 0; bus.rd_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_outputs", {bus.wr_ready, bus.rd_valid, bus.rd_last, bus.rd_done, bus.swap_done}, 5'b10000);
    check("rst_sphere", bus.rd_sphere, '0);
    check("rst_n_active", bus.n_active, 0);

    // three RGB spheres, contiguous stream
    write_op(1, 0, mk(100, -5, 20, 4, 12'hF00), 0);
    write_op(1, 1, mk(-30, 7, 40, 9, 12'h0F0), 0);
    write_op(1, 2, mk(55, 60, -8, 2, 12'h00F), 0);
    write_op(0, 0, '0, 1);
    do_swap();
    check("lit_n_active3", bus.n_active, 3);
    run_stream(0);
    check("lit_first_valid", mon_first_valid, start_at + 1);
    if (beat_sph.size() >= 3) begin
      check("lit_c0", beat_sph[0][11:0], 12'hF00);
      check("lit_c1", beat_sph[1][11:0], 12'h0F0);
      check("lit_c2", beat_sph[2][11:0], 12'h00F);
      check("lit_last", {beat_last[0], beat_last[1], beat_last[2]}, 3'b001);
      check("lit_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
      check("lit_done_after_last", mon_done_cyc, beat_cyc[2] + 1);
    end

    // sparse mask {1,4,7} with stalls
    write_op(1, 1, mk(1, 1, 1, 1, 1), 0);
    write_op(1, 4, mk(4, 4, 4, 4, 4), 0);
    write_op(1, 7, mk(7, 7, 7, 7, 7), 1);
    do_swap();
    run_stream(1);
    if (beat_sph.size() >= 3)
      check("lit_sparse", {beat_sph[0][11:0], beat_sph[1][11:0], beat_sph[2][11:0], beat_last[2]}, {12'd1, 12'd4, 12'd7, 1'b1});

    // swap request mid-stream is deferred until the stream finishes
    for (int i = 0; i < 6; i++) write_op(1, i, mk(i * 3, -i, i, i + 1, 12'h100 + i), 0);
    write_op(0, 0, '0, 1);
    s0 = swap_cnt;
    fork
      run_stream(1);
      begin
        repeat (3) @(posedge clk);
        #1 bus.swap_req = 1;
        @(posedge clk); #1 bus.swap_req = 0;
      end
    join
    @(negedge clk); #1;
    check("deferred_swap_cnt", swap_cnt - s0, 1);
    check("deferred_swap_timing", swap_cyc, mon_done_cyc + 1);
    model_swap();
    check("n_active_deferred", bus.n_active, m_count());
    check("lit_n_active6", bus.n_active, 6);
    s0 = swap_cnt;
    do_swap();
    check("no_commit_no_swap", swap_cnt - s0, 0);

    // write while pending is dropped; write+commit same cycle is kept
    write_op(1, 0, mk(9, 9, 9, 3, 12'hABC), 0);
    write_op(1, 1, mk(8, 8, 8, 3, 12'hDEF), 1);
    write_op(1, 5, mk(5, 5, 5, 3, 12'h555), 0);
    do_swap();
    check("lit_n_active2", bus.n_active, 2);
    run_stream(2);

    // empty scene
    write_op(0, 0, '0, 1);
    do_swap();
    check("lit_n_active0", bus.n_active, 0);
    run_stream(0);
    check("empty_done_at", mon_done_cyc, start_at + 1);
    check("empty_no_valid", mon_first_valid, -1);

    // reset in the middle of a stalled stream
    for (int i = 0; i < 4; i++) write_op(1, i, mk(i, i, i, 2, i), 0);
    write_op(0, 0, '0, 1);
    do_swap();
    stream_active = 1;
    @(posedge clk); #1 bus.rd_start = 1; bus.rd_ready = 0;
    @(posedge clk); #1 bus.rd_start = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1;
    check("midrst_outputs", {bus.wr_ready, bus.rd_valid, bus.rd_last, bus.rd_done, bus.swap_done}, 5'b10000);
    check("midrst_sphere", bus.rd_sphere, '0);
    check("midrst_n_active", bus.n_active, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    stream_active = 0;

    // radius cull scene
    write_op(1, 0, mk(10, 0, 0, 5, 12'h010), 0);
    write_op(1, 1, mk(11, 0, 0, 0, 12'h011), 0);
    write_op(1, 2, mk(12, 0, 0, 3, 12'h012), 0);
    write_op(1, 3, mk(13, 0, 0, 0, 12'h013), 1);
    do_swap();
    run_stream(0);
`ifdef SCENE_RADIUS_CULL_EN
    check("lit_cull_n_active", bus.n_active, 2);
    if (beat_sph.size() >= 2)
      check("lit_cull_order", {beat_sph[0][11:0], beat_sph[1][11:0], beat_last[1]}, {12'h010, 12'h012, 1'b1});
`else
    check("lit_nocull_n_active", bus.n_active, 4);
    check("lit_nocull_beats", beat_sph.size(), 4);
`endif

    // randomized scenes
    for (int round = 0; round < 12; round++) begin
      for (int w = 0; w < int'($urandom_range(0, 10)); w++)
        write_op(1, $urandom_range(0, N - 1),
                 mk($urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                    $urandom), 0);
      write_op(0, 0, '0, ($urandom_range(0, 4) != 0));
      do_swap();
      run_stream(2);
      run_stream(int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
